vec_regfile_wb: RTL and testbench
=================================

// Module: vec_regfile_wb
// PURPOSE
//  Writeback stage plus vector register file for the 6-lane datapath.
//  - Consumes the 6-lane ALU result (C) and zero flag; stores them in NREG x V-bit registers.
//  - Provides the next instruction's A/B operand vectors through two registered read ports,
//    with same-cycle write-to-read bypass.
//  - Sits directly downstream of the 6-lane ALU and upstream of its A/B operand inputs.
// PARAMETERS
//  V     192  vector width in bits (LANES*S)
//  S     32   lane / scalar width in bits
//  LANES 6    lane count; must equal V/S
//  NREG  16   number of vector registers
//  AW    4    register address width, $clog2(NREG)
// PORTS
//  clk       in   1   clock; all state updates on rising edge
//  rst       in   1   synchronous reset, active-high
//  wb_en     in   1   write request this cycle
//  wb_vec    in   1   1: write all V bits; 0: scalar write of lane 0 only
//  wb_addr   in   AW  destination register
//  wb_data   in   V   ALU result C
//  flag_we   in   1   capture flagZ_in (asserted for scalar subtract only)
//  flagZ_in  in   1   ALU zero flag
//  ra_addr   in   AW  read port A address
//  rb_addr   in   AW  read port B address
//  rd_a      out  V   operand A, registered
//  rd_b      out  V   operand B, registered
//  flag_z    out  1   architectural zero flag, registered
// BEHAVIOUR
//  Reset (rst=1 at edge): all NREG registers, rd_a, rd_b and flag_z cleared to 0.
//   rst overrides wb_en, flag_we and reads in the same cycle.
//  Write, on edge with wb_en=1 and wb_addr!=0:
//   - wb_vec=1: reg[wb_addr] <= wb_data.
//   - wb_vec=0: reg[wb_addr][S-1:0] <= wb_data[S-1:0]; lanes 1..LANES-1 are preserved.
//  Register 0 is hardwired zero: writes to it are dropped and reads return 0.
//  Read latency is 1 cycle: rd_a <= value(ra_addr) at each edge, sampled every cycle (no enable).
//  Bypass: if wb_en=1, wb_addr!=0 and wb_addr==ra_addr in the same cycle, rd_a receives the
//   post-write value.
//   - For wb_vec=0 that value is {old upper lanes, wb_data[S-1:0]}, never the raw wb_data.
//   - rd_b follows the same rules independently; both ports may hit the same address.
//  Flag: flag_z <= flagZ_in on edge when flag_we=1, else holds.
//   - flag_we is independent of wb_en; a flag-only update is legal.
//  Lane arithmetic: none. Data is stored bit-exact; no sign extension or saturation.
//  Out-of-range address (>=NREG when NREG<2**AW):
//   - Write is dropped.
//   - Read returns 0.
//  Simultaneous scalar and vector writes cannot occur (single write port).
//   Back-to-back writes to the same address resolve in order; the last edge wins.
// STRUCTURE
//  Package vec_pkg:
//   - Constants V, S, LANES, NREG, AW.
//   - typedef logic [S-1:0] lane_t; typedef lane_t [LANES-1:0] vec_t;
//     typedef logic [AW-1:0] reg_addr_t.
//  Sub-module vreg_bypass_mux: one per read port.
//   - Inputs: stored value, wb_en, wb_vec, wb_addr, wb_data, read addr.
//   - Output: merged next-read value.
//   - Instantiated twice, for A and B.
//  Storage: flip-flop array, vec_t regs[NREG].
// TESTING
//  1. Reset: rst=1 for 2 cycles after random writes -> all reads return 0; flag_z=0.
//  2. Vector write: R3 <= {6{32'hA5A5_0001}}, then ra_addr=3 -> rd_a equals that value one cycle later.
//  3. Scalar write: R3 = {6{32'h1111_1111}}, then wb_vec=0 with wb_data[31:0]=32'hDEAD_BEEF
//     -> R3 = {5{32'h1111_1111}}, 32'hDEAD_BEEF.
//  4. Bypass, both ports: wb_en=1, wb_addr=5, wb_data=V'h7,
//     ra_addr=rb_addr=5 in the same cycle -> next cycle rd_a=rd_b=V'h7.
//  5. R0: write 32'hFFFF_FFFF to addr 0 with bypass read of addr 0 -> rd_a=0 now and after.
//  6. Flag: flag_we=1, flagZ_in=1 -> flag_z=1; next cycle flag_we=0, flagZ_in=0 -> flag_z stays 1;
//     rst mid-sequence -> flag_z=0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and constants for the 6-lane vector register file / writeback stage.
//   S, LANES, V   : lane width, lane count, full vector width (LANES*S)
//   NREG, AW      : register count and address width
//   lane_t/vec_t  : one lane / a full vector as an array of lanes
//   addr_ok()     : true when an address names a writable, readable register
package vec_pkg;
  localparam int S     = 32;
  localparam int LANES = 6;
  localparam int V     = LANES * S;
  localparam int NREG  = 16;
  localparam int AW    = $clog2(NREG);

  typedef logic [S-1:0]  lane_t;
  typedef lane_t [LANES-1:0] vec_t;
  typedef logic [AW-1:0] reg_addr_t;

  // R0 is hardwired zero and addresses past NREG do not exist; both behave
  // as "no register": writes dropped, reads return zero.
  function automatic logic addr_ok(input reg_addr_t a);
    return (a != '0) && (int'(a) < NREG);
  endfunction
endpackage

// File: rtl/vreg_bypass_mux.sv
// Next-read value for one read port, merging a same-cycle write into the
// stored register value.
//   stored   : current contents of regs[rd_addr] (zero if out of range)
//   wb_*     : the write port for this cycle
//   rd_addr  : address being read
//   merged   : value the read register captures at the next edge
import vec_pkg::*;

module vreg_bypass_mux (
  input  vec_t      stored,
  input  logic      wb_en,
  input  logic      wb_vec,
  input  reg_addr_t wb_addr,
  input  vec_t      wb_data,
  input  reg_addr_t rd_addr,
  output vec_t      merged
);
  always_comb begin
    merged = stored;
    if (!addr_ok(rd_addr)) begin
      merged = '0;
    end else if (wb_en && (wb_addr == rd_addr)) begin
      // Scalar writes only replace lane 0; upper lanes keep the old value.
      if (wb_vec) merged = wb_data;
      else        merged[0] = wb_data[0];
    end
  end
endmodule

// File: rtl/vec_regfile_wb.sv
// Writeback stage and NREG x V-bit vector register file.
//   clk, rst          : clock, synchronous active-high reset
//   wb_en/wb_vec      : write request; full vector (1) or lane 0 only (0)
//   wb_addr/wb_data   : destination register and ALU result
//   flag_we/flagZ_in  : zero-flag capture enable and value
//   ra_addr/rb_addr   : read port addresses
//   rd_a/rd_b         : registered operands with write-to-read bypass
//   flag_z            : registered architectural zero flag
import vec_pkg::*;

module vec_regfile_wb (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_en,
  input  logic          wb_vec,
  input  logic [AW-1:0] wb_addr,
  input  logic [V-1:0]  wb_data,
  input  logic          flag_we,
  input  logic          flagZ_in,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [V-1:0]  rd_a,
  output logic [V-1:0]  rd_b,
  output logic          flag_z
);
  vec_t regs [NREG];
  vec_t wdata;
  vec_t stored_a, stored_b;
  vec_t next_a, next_b;

  assign wdata    = vec_t'(wb_data);
  assign stored_a = (int'(ra_addr) < NREG) ? regs[ra_addr] : '0;
  assign stored_b = (int'(rb_addr) < NREG) ? regs[rb_addr] : '0;

  vreg_bypass_mux u_mux_a (
    .stored (stored_a), .wb_en (wb_en), .wb_vec (wb_vec), .wb_addr (wb_addr),
    .wb_data(wdata),    .rd_addr(ra_addr), .merged(next_a)
  );

  vreg_bypass_mux u_mux_b (
    .stored (stored_b), .wb_en (wb_en), .wb_vec (wb_vec), .wb_addr (wb_addr),
    .wb_data(wdata),    .rd_addr(rb_addr), .merged(next_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      rd_a   <= '0;
      rd_b   <= '0;
      flag_z <= 1'b0;
    end else begin
      // R0 is never written, so it keeps its reset value of zero.
      if (wb_en && addr_ok(wb_addr)) begin
        if (wb_vec) regs[wb_addr]    <= wdata;
        else        regs[wb_addr][0] <= wdata[0];
      end
      rd_a <= next_a;
      rd_b <= next_b;
      if (flag_we) flag_z <= flagZ_in;
    end
  end
endmodule

// File: tb/tb_vec_regfile_wb.sv
// Directed bench for vec_regfile_wb: reset, vector/scalar writes, bypass on
// both ports, R0 behaviour, flag capture/hold and reset priority.
import vec_pkg::*;

module tb_vec_regfile_wb;
  logic          clk = 1'b0;
  logic          rst, wb_en, wb_vec, flag_we, flagZ_in;
  logic [AW-1:0] wb_addr, ra_addr, rb_addr;
  logic [V-1:0]  wb_data, rd_a, rd_b;
  logic          flag_z;

  int vectors = 0;
  int miscompares = 0;

  logic [V-1:0] e_a5, e_11, e_sc, e_7, e_ff, e_w1, e_w2, e_w3;

  vec_regfile_wb dut (
    .clk(clk), .rst(rst), .wb_en(wb_en), .wb_vec(wb_vec), .wb_addr(wb_addr),
    .wb_data(wb_data), .flag_we(flag_we), .flagZ_in(flagZ_in),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .rd_a(rd_a), .rd_b(rd_b), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [V-1:0] obs, input logic [V-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic vec, input logic [V-1:0] d);
    wb_en = 1'b1; wb_vec = vec; wb_addr = a; wb_data = d;
  endtask

  initial begin
    e_a5 = {6{32'hA5A5_0001}};
    e_11 = {6{32'h1111_1111}};
    e_sc = {{5{32'h1111_1111}}, 32'hDEAD_BEEF};
    e_7  = 192'h7;
    e_ff = {6{32'hFFFF_FFFF}};
    e_w1 = {6{32'h0102_0304}};
    e_w2 = {6{32'h5566_7788}};
    e_w3 = {6{32'h9999_0000}};

    rst = 1'b1; wb_en = 0; wb_vec = 0; wb_addr = 0; wb_data = '0;
    flag_we = 0; flagZ_in = 0; ra_addr = 0; rb_addr = 0;
    tick();
    rst = 1'b0;

    // 1. Random-ish writes, flag set, then 2 cycles of reset clears everything.
    wr(4'd1, 1'b1, e_w1); tick();
    wr(4'd2, 1'b1, e_w2); flag_we = 1; flagZ_in = 1; tick();
    wr(4'd9, 1'b1, e_w3); flag_we = 0; flagZ_in = 0; ra_addr = 1; rb_addr = 2; tick();
    chk("pre_reset_rd_a", rd_a, e_w1);
    chk("pre_reset_rd_b", rd_b, e_w2);
    chk("pre_reset_flag", {191'd0, flag_z}, 192'd1);
    // Reset wins over a simultaneous write and flag update.
    rst = 1; wr(4'd6, 1'b1, e_ff); flag_we = 1; flagZ_in = 1; tick();
    chk("reset_rd_a", rd_a, '0);
    chk("reset_rd_b", rd_b, '0);
    chk("reset_flag", {191'd0, flag_z}, '0);
    tick();
    rst = 0; wb_en = 0; flag_we = 0; flagZ_in = 0; ra_addr = 9; rb_addr = 6; tick();
    chk("after_reset_r9", rd_a, '0);
    chk("after_reset_r6", rd_b, '0);
    ra_addr = 1; rb_addr = 2; tick();
    chk("after_reset_r1", rd_a, '0);
    chk("after_reset_r2", rd_b, '0);
    chk("after_reset_flag", {191'd0, flag_z}, '0);

    // 2. Vector write then read one cycle later.
    wr(4'd3, 1'b1, e_a5); ra_addr = 0; rb_addr = 0; tick();
    wb_en = 0; ra_addr = 3; tick();
    chk("vec_write_r3", rd_a, e_a5);

    // 3. Scalar write replaces lane 0 only; bypassed on both ports, then stored.
    wr(4'd3, 1'b1, e_11); tick();
    wr(4'd3, 1'b0, {{5{32'hCAFE_0000}}, 32'hDEAD_BEEF}); ra_addr = 3; rb_addr = 3; tick();
    chk("scalar_bypass_a", rd_a, e_sc);
    chk("scalar_bypass_b", rd_b, e_sc);
    wb_en = 0; tick();
    chk("scalar_stored", rd_a, e_sc);

    // 4. Vector bypass on both ports, then the stored value.
    wr(4'd5, 1'b1, e_7); ra_addr = 5; rb_addr = 5; tick();
    chk("bypass_a", rd_a, e_7);
    chk("bypass_b", rd_b, e_7);
    wb_en = 0; rb_addr = 3; tick();
    chk("bypass_stored_a", rd_a, e_7);
    chk("indep_port_b", rd_b, e_sc);

    // 5. R0 stays zero even with a bypassed write.
    wr(4'd0, 1'b1, e_ff); ra_addr = 0; rb_addr = 0; tick();
    chk("r0_bypass", rd_a, '0);
    wb_en = 0; tick();
    chk("r0_after", rd_a, '0);
    chk("r0_after_b", rd_b, '0);

    // Back-to-back writes to the same address: last edge wins.
    wr(4'd7, 1'b1, e_w1); ra_addr = 0; tick();
    wr(4'd7, 1'b1, e_w2); tick();
    wb_en = 0; ra_addr = 7; tick();
    chk("last_write_wins", rd_a, e_w2);

    // 6. Flag capture, hold, flag-only update, reset.
    flag_we = 1; flagZ_in = 1; tick();
    chk("flag_set", {191'd0, flag_z}, 192'd1);
    flag_we = 0; flagZ_in = 0; tick();
    chk("flag_hold", {191'd0, flag_z}, 192'd1);
    rst = 1; tick();
    chk("flag_reset", {191'd0, flag_z}, '0);
    rst = 0; flag_we = 1; flagZ_in = 1; tick();
    flag_we = 1; flagZ_in = 0; tick();
    chk("flag_clear_we", {191'd0, flag_z}, '0);
    flag_we = 0;
    chk("reset_cleared_r7", rd_a, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
